// File: rtl/cache_port_arbiter_if.sv
// Handshake bundle for cache_port_arbiter: fetch port, load/store port, cache-side port and status.
// The slave modport is the arbiter's view; the master modport is the surrounding core/cache.
interface cache_port_arbiter_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic              i_valid_i;
    logic [ADDR_W-1:0] i_addr_i;
    logic              i_ready_o;
    logic              i_rvalid_o;
    logic [DATA_W-1:0] i_rdata_o;

    logic              d_valid_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [DATA_W-1:0] d_wdata_i;
    logic [STRB_W-1:0] d_wstrb_i;
    logic              d_ready_o;
    logic              d_rvalid_o;
    logic [DATA_W-1:0] d_rdata_o;

    logic              m_valid_o;
    logic [ADDR_W-1:0] m_addr_o;
    logic [DATA_W-1:0] m_wdata_o;
    logic [STRB_W-1:0] m_wstrb_o;
    logic              m_ready_i;
    logic              m_rvalid_i;
    logic [DATA_W-1:0] m_rdata_i;

    logic              busy_o;
    logic              err_o;

    modport slave (
        input  i_valid_i, i_addr_i,
        output i_ready_o, i_rvalid_o, i_rdata_o,
        input  d_valid_i, d_addr_i, d_wdata_i, d_wstrb_i,
        output d_ready_o, d_rvalid_o, d_rdata_o,
        output m_valid_o, m_addr_o, m_wdata_o, m_wstrb_o,
        input  m_ready_i, m_rvalid_i, m_rdata_i,
        output busy_o, err_o
    );

    modport master (
        output i_valid_i, i_addr_i,
        input  i_ready_o, i_rvalid_o, i_rdata_o,
        output d_valid_i, d_addr_i, d_wdata_i, d_wstrb_i,
        input  d_ready_o, d_rvalid_o, d_rdata_o,
        input  m_valid_o, m_addr_o, m_wdata_o, m_wstrb_o,
        output m_ready_i, m_rvalid_i, m_rdata_i,
        input  busy_o, err_o
    );
endinterface

// File: rtl/cache_port_arbiter.sv
// Shares the data cache IOB front-end between instruction fetch (I) and load/store (D), one read outstanding.
// Define CACHE_ARB_RR_EN for round-robin contention; otherwise D has fixed priority.
module cache_port_arbiter #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
) (
    input logic                   clk,
    input logic                   reset,
    cache_port_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOCK    = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   owner, owner_nxt;
    logic   last, last_nxt;
    logic   err, err_nxt;

    logic   contend_win;
    logic   sel;
    logic   req_valid;
    logic   accept;
    logic   is_write;
    logic   rsp;

`ifdef CACHE_ARB_RR_EN
    assign contend_win = ~last;
`else
    logic last_unused;
    assign contend_win = 1'b1;
    assign last_unused = last;
`endif

    // Requester selection: combinational grant in IDLE, pinned to the owner otherwise.
    always_comb begin
        sel = owner;
        if (state == IDLE) begin
            if (bus.i_valid_i && bus.d_valid_i) begin
                sel = contend_win;
            end else begin
                sel = bus.d_valid_i;
            end
        end
    end

    assign req_valid = !reset && (state == IDLE || state == LOCK) &&
                       (sel ? bus.d_valid_i : bus.i_valid_i);
    assign accept    = req_valid && bus.m_ready_i;
    assign is_write  = sel && (bus.d_wstrb_i != '0);
    assign rsp       = !reset && (state == WAIT_RD) && bus.m_rvalid_i;

    assign bus.m_valid_o  = req_valid;
    assign bus.m_addr_o   = req_valid ? (sel ? bus.d_addr_i : bus.i_addr_i) : '0;
    assign bus.m_wdata_o  = (req_valid && sel) ? bus.d_wdata_i : '0;
    assign bus.m_wstrb_o  = (req_valid && sel) ? bus.d_wstrb_i : '0;

    assign bus.i_ready_o  = accept && !sel;
    assign bus.d_ready_o  = accept && sel;
    assign bus.i_rvalid_o = rsp && !owner;
    assign bus.d_rvalid_o = rsp && owner;
    assign bus.i_rdata_o  = bus.m_rdata_i;
    assign bus.d_rdata_o  = bus.m_rdata_i;

    assign bus.busy_o     = (state != IDLE);
    assign bus.err_o      = err;

    // Read data arriving with nothing outstanding is dropped and flagged permanently.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last;
        err_nxt   = err | (bus.m_rvalid_i && (state != WAIT_RD));
        case (state)
            IDLE, LOCK: begin
                if (accept) begin
                    owner_nxt = sel;
                    last_nxt  = sel;
                    state_nxt = is_write ? IDLE : WAIT_RD;
                end else if (req_valid) begin
                    owner_nxt = sel;
                    state_nxt = LOCK;
                end else begin
                    state_nxt = IDLE;
                end
            end
            WAIT_RD: begin
                if (bus.m_rvalid_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            owner <= 1'b0;
            last  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            last  <= last_nxt;
            err   <= err_nxt;
        end
    end
endmodule

// File: tb/tb_cache_port_arbiter.sv
// Scoreboard bench for cache_port_arbiter: random requesters and cache plus directed corner cases.
module tb_cache_port_arbiter;
    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } req_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cache_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    cache_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    req_t        req_q_i[$];
    req_t        req_q_d[$];
    logic [31:0] rd_q_i[$];
    logic [31:0] rd_q_d[$];

    bit rand_en  = 1'b0;
    bit cache_en = 1'b0;
    bit i_fire   = 1'b0;
    bit d_fire   = 1'b0;
    bit m_fire   = 1'b0;
    bit m_fire_rd = 1'b0;
    logic [ADDR_W-1:0] m_fire_addr;

    bit pend = 1'b0;
    int pend_cnt = 0;
    logic [ADDR_W-1:0] pend_addr;

    // Reference model: read outstanding, lock holder, last winner, sticky error.
    bit mdl_rd = 1'b0, mdl_rd_owner = 1'b0;
    bit mdl_lock = 1'b0, mdl_lock_owner = 1'b0;
    bit mdl_last = 1'b0, mdl_err = 1'b0;

    function automatic logic [31:0] rd_for(input logic [ADDR_W-1:0] a);
        return ({2'b00, a} * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue_i(input logic [ADDR_W-1:0] a, input logic [31:0] rd);
        req_t r;
        r.addr = a; r.wdata = '0; r.wstrb = '0;
        bus.i_addr_i  = a;
        bus.i_valid_i = 1'b1;
        req_q_i.push_back(r);
        rd_q_i.push_back(rd);
    endtask

    task automatic issue_d(input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                           input logic [STRB_W-1:0] ws, input logic [31:0] rd);
        req_t r;
        r.addr = a; r.wdata = wd; r.wstrb = ws;
        bus.d_addr_i  = a;
        bus.d_wdata_i = wd;
        bus.d_wstrb_i = ws;
        bus.d_valid_i = 1'b1;
        req_q_d.push_back(r);
        if (ws == '0) rd_q_d.push_back(rd);
    endtask

    // Requesters: drop valid once accepted; issue new random requests while enabled.
    initial forever begin
        logic [31:0] r;
        @(posedge clk);
        #1;
        if (i_fire) bus.i_valid_i = 1'b0;
        if (d_fire) bus.d_valid_i = 1'b0;
        if (rand_en && !bus.i_valid_i && $urandom_range(0, 2) == 0) begin
            r = $urandom;
            issue_i(r[ADDR_W-1:0], rd_for(r[ADDR_W-1:0]));
        end
        if (rand_en && !bus.d_valid_i && $urandom_range(0, 2) == 0) begin
            r = $urandom;
            issue_d(r[ADDR_W-1:0], $urandom,
                    ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15)),
                    rd_for(r[ADDR_W-1:0]));
        end
    end

    // Cache model: random ready, read data 0..3 cycles after an accepted read.
    initial forever begin
        @(posedge clk);
        #1;
        if (cache_en) begin
            bus.m_ready_i = ($urandom_range(0, 2) != 0);
            if (m_fire && m_fire_rd) begin
                pend      = 1'b1;
                pend_cnt  = $urandom_range(0, 3);
                pend_addr = m_fire_addr;
            end
            if (pend && pend_cnt == 0) begin
                bus.m_rvalid_i = 1'b1;
                bus.m_rdata_i  = rd_for(pend_addr);
                pend = 1'b0;
            end else begin
                bus.m_rvalid_i = 1'b0;
                bus.m_rdata_i  = $urandom;
                if (pend) pend_cnt--;
            end
        end
    end

    // Monitor: compare against the model every cycle and pop scoreboard queues on handshakes.
    always @(negedge clk) begin : monitor
        int   w;
        bit   iv, dv;
        req_t e;
        iv = bus.i_valid_i;
        dv = bus.d_valid_i;
        if (reset) begin
            check_output("rst_outputs",
                         {bus.m_valid_o, bus.i_ready_o, bus.d_ready_o, bus.i_rvalid_o, bus.d_rvalid_o}, '0);
            mdl_rd = 0; mdl_lock = 0; mdl_last = 0; mdl_err = 0;
            rd_q_i.delete();
            rd_q_d.delete();
            i_fire = 0; d_fire = 0; m_fire = 0;
        end else begin
            if (mdl_rd) w = -1;
            else if (mdl_lock) w = (mdl_lock_owner ? dv : iv) ? int'(mdl_lock_owner) : -1;
`ifdef CACHE_ARB_RR_EN
            else if (iv && dv) w = mdl_last ? 0 : 1;
`else
            else if (iv && dv) w = 1;
`endif
            else if (dv) w = 1;
            else if (iv) w = 0;
            else w = -1;

            check_output("m_valid", bus.m_valid_o, w >= 0);
            check_output("i_ready", bus.i_ready_o, (w == 0) && bus.m_ready_i);
            check_output("d_ready", bus.d_ready_o, (w == 1) && bus.m_ready_i);
            check_output("i_rvalid", bus.i_rvalid_o, mdl_rd && bus.m_rvalid_i && !mdl_rd_owner);
            check_output("d_rvalid", bus.d_rvalid_o, mdl_rd && bus.m_rvalid_i && mdl_rd_owner);
            check_output("busy", bus.busy_o, mdl_rd || mdl_lock);
            check_output("err", bus.err_o, mdl_err);
            check_output("rdata_pass", {bus.i_rdata_o, bus.d_rdata_o}, {bus.m_rdata_i, bus.m_rdata_i});
            if (!iv && !dv)
                check_output("m_bus_idle", {bus.m_addr_o, bus.m_wdata_o, bus.m_wstrb_o}, '0);

            if (bus.i_ready_o) begin
                check_output("i_req_avail", req_q_i.size() != 0, 1);
                if (req_q_i.size() != 0) begin
                    e = req_q_i.pop_front();
                    check_output("i_req", {bus.m_addr_o, bus.m_wdata_o, bus.m_wstrb_o}, e);
                end
            end
            if (bus.d_ready_o) begin
                check_output("d_req_avail", req_q_d.size() != 0, 1);
                if (req_q_d.size() != 0) begin
                    e = req_q_d.pop_front();
                    check_output("d_req", {bus.m_addr_o, bus.m_wdata_o, bus.m_wstrb_o}, e);
                end
            end
            if (bus.i_rvalid_o) begin
                check_output("i_rd_avail", rd_q_i.size() != 0, 1);
                if (rd_q_i.size() != 0) check_output("i_rdata", bus.i_rdata_o, rd_q_i.pop_front());
            end
            if (bus.d_rvalid_o) begin
                check_output("d_rd_avail", rd_q_d.size() != 0, 1);
                if (rd_q_d.size() != 0) check_output("d_rdata", bus.d_rdata_o, rd_q_d.pop_front());
            end

            if (bus.m_rvalid_i) begin
                if (mdl_rd) mdl_rd = 0;
                else mdl_err = 1;
            end
            if (w >= 0) begin
                if (bus.m_ready_i) begin
                    mdl_last = (w == 1);
                    mdl_lock = 0;
                    if (w == 0 || bus.d_wstrb_i == '0) begin
                        mdl_rd = 1;
                        mdl_rd_owner = (w == 1);
                    end
                end else begin
                    mdl_lock = 1;
                    mdl_lock_owner = (w == 1);
                end
            end else begin
                mdl_lock = 0;
            end

            i_fire      = iv && bus.i_ready_o;
            d_fire      = dv && bus.d_ready_o;
            m_fire      = bus.m_valid_o && bus.m_ready_i;
            m_fire_rd   = (bus.m_wstrb_o == '0);
            m_fire_addr = bus.m_addr_o;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        bus.i_valid_i = 0; bus.i_addr_i = '0;
        bus.d_valid_i = 0; bus.d_addr_i = '0; bus.d_wdata_i = '0; bus.d_wstrb_i = '0;
        bus.m_ready_i = 0; bus.m_rvalid_i = 0; bus.m_rdata_i = '0;
        apply_stimulus(3);
        reset = 1'b0;
        apply_stimulus(2);

        // Random traffic
        rand_en = 1; cache_en = 1;
        apply_stimulus(3000);
        rand_en = 0;
        for (int k = 0; k < 300; k++) begin
            if (req_q_i.size() == 0 && req_q_d.size() == 0 && rd_q_i.size() == 0 &&
                rd_q_d.size() == 0 && !bus.busy_o && !pend) break;
            apply_stimulus(1);
        end
        check_output("drain", {req_q_i.size(), req_q_d.size(), rd_q_i.size(), rd_q_d.size()}, '0);
        cache_en = 0;
        apply_stimulus(1);
        bus.m_ready_i = 0; bus.m_rvalid_i = 0;
        apply_stimulus(1);

        // Single fetch with three-cycle read latency
        issue_i(30'h10, 32'hDEAD_BEEF);
        bus.m_ready_i = 1;
        apply_stimulus(1);
        bus.m_ready_i = 0;
        apply_stimulus(2);
        bus.m_rvalid_i = 1; bus.m_rdata_i = 32'hDEAD_BEEF;
        apply_stimulus(1);
        bus.m_rvalid_i = 0;
        apply_stimulus(1);

        // Contention: D write against I read
        issue_i(30'h11, 32'hCAFE_F00D);
        issue_d(30'h20, 32'hA5A5_A5A5, 4'hF, 32'h0);
        bus.m_ready_i = 1;
        apply_stimulus(2);
        bus.m_ready_i = 0;
        apply_stimulus(1);
        bus.m_rvalid_i = 1; bus.m_rdata_i = 32'hCAFE_F00D;
        apply_stimulus(1);
        bus.m_rvalid_i = 0;
        apply_stimulus(1);

        // Lock hold, routing, I granted the cycle after rvalid
        issue_d(30'h40, 32'h0, 4'h0, 32'h1234_5678);
        issue_i(30'h30, 32'h0BAD_F00D);
        apply_stimulus(4);
        bus.m_ready_i = 1;
        apply_stimulus(2);
        bus.m_rvalid_i = 1; bus.m_rdata_i = 32'h1234_5678;
        apply_stimulus(1);
        bus.m_rvalid_i = 0;
        apply_stimulus(1);
        bus.m_ready_i = 0;
        apply_stimulus(1);
        bus.m_rvalid_i = 1; bus.m_rdata_i = 32'h0BAD_F00D;
        apply_stimulus(1);
        bus.m_rvalid_i = 0;
        apply_stimulus(1);

        // Owner drops valid while locked
        bus.d_addr_i = 30'h50; bus.d_wstrb_i = 4'h0; bus.d_valid_i = 1;
        apply_stimulus(1);
        bus.d_valid_i = 0;
        apply_stimulus(2);

        // Spurious rvalid in IDLE, error must stick
        bus.m_rvalid_i = 1; bus.m_rdata_i = 32'h7777_7777;
        apply_stimulus(1);
        bus.m_rvalid_i = 0;
        apply_stimulus(3);

        // Reset while waiting for read data, then a late rvalid
        issue_d(30'h60, 32'h0, 4'h0, 32'h0);
        bus.m_ready_i = 1;
        apply_stimulus(1);
        bus.m_ready_i = 0;
        apply_stimulus(1);
        reset = 1;
        apply_stimulus(1);
        reset = 0;
        apply_stimulus(1);
        bus.m_rvalid_i = 1; bus.m_rdata_i = 32'h5555_AAAA;
        apply_stimulus(1);
        bus.m_rvalid_i = 0;
        apply_stimulus(3);

        check_output("final_queues", {req_q_i.size(), req_q_d.size(), rd_q_i.size(), rd_q_d.size()}, '0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
